// File: rtl/sel_mux_reg_pkg.sv
// Shared level/enable encodings for the registered word selector and its
// priority encoder.
package sel_mux_reg_pkg;

   typedef enum bit {
      LOW  = 1'b0,
      HIGH = 1'b1
   } level_e;

   typedef enum bit {
      DISABLE = 1'b0,
      ENABLE  = 1'b1
   } enable_e;

endpackage : sel_mux_reg_pkg

// File: rtl/sel_pri_enc.sv
// Combinational IN-bit priority encoder to one-hot; MSB=ENABLE favours the
// highest set request, MSB=DISABLE the lowest.
module sel_pri_enc
   import sel_mux_reg_pkg::*;
#(
   parameter int unsigned IN  = 4,
   parameter enable_e     MSB = ENABLE
) (
   input  logic [IN-1:0] req_i,
   output logic [IN-1:0] grant_c
);

   // blk_c marks that a higher-priority request has already claimed the grant
   logic [IN:0] blk_c;

   generate
      if (MSB == ENABLE) begin : g_msb
         assign blk_c[IN] = 1'b0;
         for (genvar i = 0; i < IN; i++) begin : g_bit
            assign blk_c[i]   = blk_c[i+1] | req_i[i];
            assign grant_c[i] = req_i[i] & ~blk_c[i+1];
         end
      end else begin : g_lsb
         assign blk_c[0] = 1'b0;
         for (genvar i = 0; i < IN; i++) begin : g_bit
            assign blk_c[i+1] = blk_c[i] | req_i[i];
            assign grant_c[i] = req_i[i] & ~blk_c[i];
         end
      end
   endgenerate

endmodule : sel_pri_enc

// File: rtl/sel_mux_reg.sv
// N-input word selector with registered valid/one-hot/word outputs; sel is
// either a binary index or an active-level bit vector with priority.
module sel_mux_reg
   import sel_mux_reg_pkg::*;
#(
   parameter int unsigned DATA      = 32,
   parameter int unsigned IN        = 4,
   parameter int unsigned SEL_WIDTH = $clog2(IN),
   parameter level_e      MODE      = LOW,
   parameter level_e      ACT       = HIGH,
   parameter enable_e     MSB       = ENABLE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA*IN-1:0]   in,
   input  logic [SEL_WIDTH-1:0] sel,
   output logic                 valid,
   output logic [IN-1:0]        pos,
   output logic [DATA-1:0]      out
);

   logic [IN-1:0]   pos_d;
   logic [IN-1:0]   pos_q;
   logic [DATA-1:0] out_d;
   logic [DATA-1:0] out_q;
   logic            valid_d;
   logic            valid_q;

   generate
      if (MODE == LOW) begin : g_binary
         // indices >= IN match no decoder output, so nothing is selected
         for (genvar i = 0; i < IN; i++) begin : g_dec
            assign pos_d[i] = (sel == SEL_WIDTH'(i));
         end
      end else begin : g_vector
         logic [IN-1:0] req_c;

         for (genvar i = 0; i < IN; i++) begin : g_req
            assign req_c[i] = (sel[i] == 1'(ACT));
         end

         if (SEL_WIDTH > IN) begin : g_excess
            logic unused_sel_hi;
            assign unused_sel_hi = ^sel[SEL_WIDTH-1:IN];
         end

         sel_pri_enc #(
            .IN  (IN),
            .MSB (MSB)
         ) u_pri_enc (
            .req_i   (req_c),
            .grant_c (pos_d)
         );
      end
   endgenerate

   // AND-OR word mux gated by the one-hot pick; all-zero when nothing picked
   logic [DATA-1:0] acc_c [IN+1];

   assign acc_c[0] = '0;

   generate
      for (genvar i = 0; i < IN; i++) begin : g_mux
         assign acc_c[i+1] = acc_c[i] | (in[DATA*i +: DATA] & {DATA{pos_d[i]}});
      end
   endgenerate

   assign out_d   = acc_c[IN];
   assign valid_d = |pos_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pos_q   <= '0;
         out_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pos_q   <= pos_d;
         out_q   <= out_d;
      end
   end

   assign valid = valid_q;
   assign pos   = pos_q;
   assign out   = out_q;

endmodule : sel_mux_reg

// File: tb/tb_sel_mux_reg.sv
// Directed bench for sel_mux_reg across binary, MSB/LSB-priority, active-low
// and non-power-of-two configurations.
module tb_sel_mux_reg;
   import sel_mux_reg_pkg::*;

   logic clk;
   logic reset;

   logic [127:0] in4;
   logic [95:0]  in3;

   logic [1:0]  sel_bin;
   logic [31:0] sel_msb;
   logic [3:0]  sel_lsb;
   logic [3:0]  sel_alo;
   logic [1:0]  sel_bin3;

   logic        valid_bin,  valid_msb,  valid_lsb,  valid_alo,  valid_bin3;
   logic [3:0]  pos_bin,    pos_msb,    pos_lsb,    pos_alo;
   logic [2:0]  pos_bin3;
   logic [31:0] out_bin,    out_msb,    out_lsb,    out_alo,    out_bin3;

   int compared   = 0;
   int mismatched = 0;

   sel_mux_reg #(.DATA(32), .IN(4), .SEL_WIDTH(2), .MODE(LOW)) u_bin (
      .clk(clk), .reset(reset), .in(in4), .sel(sel_bin),
      .valid(valid_bin), .pos(pos_bin), .out(out_bin));

   sel_mux_reg #(.DATA(32), .IN(4), .SEL_WIDTH(32), .MODE(HIGH), .ACT(HIGH), .MSB(ENABLE)) u_msb (
      .clk(clk), .reset(reset), .in(in4), .sel(sel_msb),
      .valid(valid_msb), .pos(pos_msb), .out(out_msb));

   sel_mux_reg #(.DATA(32), .IN(4), .SEL_WIDTH(4), .MODE(HIGH), .ACT(HIGH), .MSB(DISABLE)) u_lsb (
      .clk(clk), .reset(reset), .in(in4), .sel(sel_lsb),
      .valid(valid_lsb), .pos(pos_lsb), .out(out_lsb));

   sel_mux_reg #(.DATA(32), .IN(4), .SEL_WIDTH(4), .MODE(HIGH), .ACT(LOW), .MSB(ENABLE)) u_alo (
      .clk(clk), .reset(reset), .in(in4), .sel(sel_alo),
      .valid(valid_alo), .pos(pos_alo), .out(out_alo));

   sel_mux_reg #(.DATA(32), .IN(3), .SEL_WIDTH(2), .MODE(LOW)) u_bin3 (
      .clk(clk), .reset(reset), .in(in3), .sel(sel_bin3),
      .valid(valid_bin3), .pos(pos_bin3), .out(out_bin3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag,
                       input logic v, input logic [3:0] p, input logic [31:0] o,
                       input logic ev, input logic [3:0] ep, input logic [31:0] eo);
      chk({tag, ".valid"}, 32'(v), 32'(ev));
      chk({tag, ".pos"},   32'(p), 32'(ep));
      chk({tag, ".out"},   o,      eo);
   endtask

   initial begin
      in4      = {32'd4, 32'd3, 32'd2, 32'd1};
      in3      = {32'd3, 32'd2, 32'd1};
      reset    = 1'b1;
      sel_bin  = 2'd2;
      sel_msb  = 32'h0000_0008;
      sel_lsb  = 4'b1111;
      sel_alo  = 4'b0000;
      sel_bin3 = 2'd1;

      // reset with active selections everywhere
      tick();
      chk3("rst_bin", valid_bin, pos_bin, out_bin, 1'b0, 4'b0000, 32'd0);
      chk3("rst_msb", valid_msb, pos_msb, out_msb, 1'b0, 4'b0000, 32'd0);
      chk("rst_lsb.out", out_lsb, 32'd0);
      chk("rst_alo.out", out_alo, 32'd0);
      chk("rst_bin3.out", out_bin3, 32'd0);

      // release: outputs hold zero until the next rising edge
      reset = 1'b0;
      #3;
      chk("rel_pre_edge.valid", 32'(valid_bin), 32'd0);
      tick();
      chk3("rel_bin", valid_bin, pos_bin, out_bin, 1'b1, 4'b0100, 32'd3);

      // binary index
      sel_bin = 2'd0; tick();
      chk3("bin0", valid_bin, pos_bin, out_bin, 1'b1, 4'b0001, 32'd1);
      sel_bin = 2'd1; tick();
      chk3("bin1", valid_bin, pos_bin, out_bin, 1'b1, 4'b0010, 32'd2);
      sel_bin = 2'd2; tick();
      chk3("bin2", valid_bin, pos_bin, out_bin, 1'b1, 4'b0100, 32'd3);
      sel_bin = 2'd3; tick();
      chk3("bin3", valid_bin, pos_bin, out_bin, 1'b1, 4'b1000, 32'd4);

      // one-cycle latency: new sel not visible before the edge
      sel_bin = 2'd0;
      #3;
      chk("lat_hold.out", out_bin, 32'd4);
      tick();
      chk("lat_new.out", out_bin, 32'd1);

      // MSB priority, active-high, 32-bit sel
      sel_msb = 32'h0000_0001; tick();
      chk3("msb_0001", valid_msb, pos_msb, out_msb, 1'b1, 4'b0001, 32'd1);
      sel_msb = 32'h0000_0002; tick();
      chk("msb_0010.out", out_msb, 32'd2);
      sel_msb = 32'h0000_0004; tick();
      chk("msb_0100.out", out_msb, 32'd3);
      sel_msb = 32'h0000_0008; tick();
      chk("msb_1000.out", out_msb, 32'd4);
      sel_msb = 32'h0000_0003; tick();
      chk3("msb_0011", valid_msb, pos_msb, out_msb, 1'b1, 4'b0010, 32'd2);
      sel_msb = 32'h0000_0005; tick();
      chk3("msb_0101", valid_msb, pos_msb, out_msb, 1'b1, 4'b0100, 32'd3);
      sel_msb = 32'h0000_000F; tick();
      chk3("msb_1111", valid_msb, pos_msb, out_msb, 1'b1, 4'b1000, 32'd4);
      sel_msb = 32'h0000_0000; tick();
      chk3("msb_none", valid_msb, pos_msb, out_msb, 1'b0, 4'b0000, 32'd0);

      // excess sel bits above IN are ignored
      sel_msb = 32'h6000_0008; tick();
      chk3("xs_1000", valid_msb, pos_msb, out_msb, 1'b1, 4'b1000, 32'd4);
      sel_msb = 32'h6000_0000; tick();
      chk3("xs_0000", valid_msb, pos_msb, out_msb, 1'b0, 4'b0000, 32'd0);
      sel_msb = 32'hF000_0002; tick();
      chk3("xs_0010", valid_msb, pos_msb, out_msb, 1'b1, 4'b0010, 32'd2);

      // LSB priority
      sel_lsb = 4'b0110; tick();
      chk3("lsb_0110", valid_lsb, pos_lsb, out_lsb, 1'b1, 4'b0010, 32'd2);
      sel_lsb = 4'b1100; tick();
      chk3("lsb_1100", valid_lsb, pos_lsb, out_lsb, 1'b1, 4'b0100, 32'd3);
      sel_lsb = 4'b1111; tick();
      chk3("lsb_1111", valid_lsb, pos_lsb, out_lsb, 1'b1, 4'b0001, 32'd1);
      sel_lsb = 4'b0000; tick();
      chk3("lsb_none", valid_lsb, pos_lsb, out_lsb, 1'b0, 4'b0000, 32'd0);

      // active-low bit vector
      sel_alo = 4'b1111; tick();
      chk3("alo_1111", valid_alo, pos_alo, out_alo, 1'b0, 4'b0000, 32'd0);
      sel_alo = 4'b1101; tick();
      chk3("alo_1101", valid_alo, pos_alo, out_alo, 1'b1, 4'b0010, 32'd2);
      sel_alo = 4'b0000; tick();
      chk3("alo_0000", valid_alo, pos_alo, out_alo, 1'b1, 4'b1000, 32'd4);

      // binary IN=3: index 3 is out of range
      sel_bin3 = 2'd3; tick();
      chk3("bin3_idx3", valid_bin3, {1'b0, pos_bin3}, out_bin3, 1'b0, 4'b0000, 32'd0);
      sel_bin3 = 2'd2; tick();
      chk3("bin3_idx2", valid_bin3, {1'b0, pos_bin3}, out_bin3, 1'b1, 4'b0100, 32'd3);

      // reset overrides a selection in flight
      sel_bin = 2'd1;
      reset   = 1'b1;
      tick();
      chk3("rst_flight", valid_bin, pos_bin, out_bin, 1'b0, 4'b0000, 32'd0);
      reset = 1'b0;
      tick();
      chk3("post_rst", valid_bin, pos_bin, out_bin, 1'b1, 4'b0010, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_sel_mux_reg
